// File: rtl/u712_cpu_ram_request_pkg.sv
// Shared constants and types for the U712 CPU-to-chip-RAM request path.
// State encoding, timeout limit, chip RAM decode and the line-burst TT code live here.
package u712_cpu_ram_request_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        TERM = 2'd3
    } state_t;

    localparam logic [7:0]   TIMEOUT_LIMIT    = 8'd255;
    localparam logic [31:21] CHIP_DECODE_MASK = '1;
    localparam logic [1:0]   TT_BURST         = 2'b01;  // {TT1, TT0}
    localparam int           BEAT_CNT_W       = 2;

    // Chip RAM occupies the bottom 2 MB: every masked upper address bit must be zero.
    function automatic logic is_chip_ram(input logic [31:0] addr);
        return (addr[31:21] & CHIP_DECODE_MASK) == '0;
    endfunction

endpackage

// File: rtl/u712_cpu_ram_request_beat_counter.sv
// Beat counter and LA[3:2] line-wrap for 68040 burst transfers.
// LA[3:2] advances only on beats of an accepted burst and wraps modulo 4.
module u712_cpu_ram_request_beat_counter
    import u712_cpu_ram_request_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic [1:0]            la32_init_i,
    input  logic                  beat_i,
    input  logic                  wrap_i,
    output logic [BEAT_CNT_W-1:0] count_o,
    output logic [1:0]            la32_o
);

    logic [BEAT_CNT_W-1:0] count_q;
    logic [1:0]            la32_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            la32_q  <= '0;
        end else if (load_i) begin
            count_q <= '0;
            la32_q  <= la32_init_i;
        end else if (beat_i) begin
            count_q <= count_q + 1'b1;
            if (wrap_i) begin
                la32_q <= la32_q + 2'd1;
            end
        end
    end

    assign count_o = count_q;
    assign la32_o  = la32_q;

endmodule

// File: rtl/u712_cpu_ram_request.sv
// 68040 transfer-start to chip RAM request bridge: decodes, latches the address,
// paces nTA per RAM beat, handles burst wrap/inhibit and a bus-error timeout.
module u712_cpu_ram_request
    import u712_cpu_ram_request_pkg::*;
(
    input  logic        CLK80_i,
    input  logic        nRESET_i,
    input  logic        CLK40_i,
    input  logic        nTS_i,
    input  logic [31:0] A_i,
    input  logic        RnW_i,
    input  logic        TT0_i,
    input  logic        TT1_i,
    input  logic        RAM_TA_i,
    input  logic        BURST_CYCLE_i,
    output logic        nRAMSPACE_o,
    output logic [20:1] LA_o,
    output logic        LRnW_o,
    output logic        LTT0_o,
    output logic        LTT1_o,
    output logic        nTA_o,
    output logic        nTBI_o,
    output logic        nTEA_o
);

    state_t      state_q;
    logic [20:4] la_hi_q;
    logic        la1_q;
    logic        lrnw_q, ltt0_q, ltt1_q;
    logic        burst_req_q, burst_ok_q, hold_q, last_q, term_q;
    logic        nram_q, nta_q, ntbi_q, ntea_q;
    logic [7:0]  tmo_q;

    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [1:0]            la32;

    logic hit, first_beat, wait_st, beat, reject_burst, accept, final_beat, timeout;
    logic unused_a0;

    assign unused_a0 = A_i[0];

    assign hit          = (state_q == IDLE) && !nTS_i && CLK40_i && is_chip_ram(A_i);
    assign first_beat   = (state_q == REQ);
    assign wait_st      = first_beat || ((state_q == DATA) && !last_q);
    // hold_q blocks the second half of an nTA pulse from being taken as a new beat
    assign beat         = wait_st && !hold_q && RAM_TA_i && !CLK40_i;
    assign reject_burst = burst_req_q && !BURST_CYCLE_i;
    assign accept       = first_beat ? (burst_req_q && BURST_CYCLE_i) : burst_ok_q;
    assign final_beat   = !accept || (beat_cnt == 2'd3);
    assign timeout      = wait_st && !beat && (tmo_q == TIMEOUT_LIMIT - 8'd1);

    u712_cpu_ram_request_beat_counter u_beat_cnt (
        .clk_i       (CLK80_i),
        .rst_n_i     (nRESET_i),
        .load_i      (hit),
        .la32_init_i (A_i[3:2]),
        .beat_i      (beat),
        .wrap_i      (accept),
        .count_o     (beat_cnt),
        .la32_o      (la32)
    );

    always_ff @(posedge CLK80_i) begin
        if (!nRESET_i) begin
            state_q     <= IDLE;
            la_hi_q     <= '0;
            la1_q       <= 1'b0;
            lrnw_q      <= 1'b1;
            ltt0_q      <= 1'b0;
            ltt1_q      <= 1'b0;
            burst_req_q <= 1'b0;
            burst_ok_q  <= 1'b0;
            hold_q      <= 1'b0;
            last_q      <= 1'b0;
            term_q      <= 1'b0;
            nram_q      <= 1'b1;
            nta_q       <= 1'b1;
            ntbi_q      <= 1'b1;
            ntea_q      <= 1'b1;
            tmo_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (hit) begin
                    state_q     <= REQ;
                    nram_q      <= 1'b0;
                    tmo_q       <= '0;
                    la_hi_q     <= A_i[20:4];
                    la1_q       <= A_i[1];
                    lrnw_q      <= RnW_i;
                    ltt0_q      <= TT0_i;
                    ltt1_q      <= TT1_i;
                    burst_req_q <= ({TT1_i, TT0_i} == TT_BURST);
                    burst_ok_q  <= 1'b0;
                    hold_q      <= 1'b0;
                    last_q      <= 1'b0;
                end
                REQ, DATA: begin
                    if (beat) begin
                        state_q <= DATA;
                        nta_q   <= 1'b0;
                        hold_q  <= 1'b1;
                        tmo_q   <= '0;
                        if (first_beat) begin
                            burst_ok_q <= accept;
                            ntbi_q     <= !reject_burst;
                        end
                        // drop the request on the nTA edge so the controller cannot restart
                        if (final_beat) begin
                            last_q <= 1'b1;
                            nram_q <= 1'b1;
                        end
                    end else begin
                        hold_q <= 1'b0;
                        if (!hold_q) begin
                            nta_q  <= 1'b1;
                            ntbi_q <= 1'b1;
                        end
                        if (last_q && !hold_q) begin
                            state_q <= TERM;
                            term_q  <= 1'b0;
                        end else if (timeout) begin
                            state_q <= TERM;
                            term_q  <= 1'b0;
                            ntea_q  <= 1'b0;
                            nram_q  <= 1'b1;
                            tmo_q   <= '0;
                        end else if (wait_st) begin
                            tmo_q <= tmo_q + 8'd1;
                        end
                    end
                end
                TERM: begin
                    if (!term_q) begin
                        term_q <= 1'b1;
                    end else begin
                        term_q  <= 1'b0;
                        ntea_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign nRAMSPACE_o = nram_q;
    assign LA_o        = {la_hi_q, la32, la1_q};
    assign LRnW_o      = lrnw_q;
    assign LTT0_o      = ltt0_q;
    assign LTT1_o      = ltt1_q;
    assign nTA_o       = nta_q;
    assign nTBI_o      = ntbi_q;
    assign nTEA_o      = ntea_q;

endmodule

// File: tb/tb_u712_cpu_ram_request.sv
// Randomised plus directed bench for u712_cpu_ram_request against a
// transaction-level model built from beat/timeout timestamps.
module tb_u712_cpu_ram_request;

    logic        clk80 = 1'b0;
    logic        nreset, clk40, nts, rnw, tt0, tt1, ram_ta, burst_cycle;
    logic [31:0] a;
    logic        nramspace, lrnw, ltt0, ltt1, nta, ntbi, ntea;
    logic [20:1] la;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #6 clk80 = ~clk80;

    u712_cpu_ram_request dut (
        .CLK80_i       (clk80),
        .nRESET_i      (nreset),
        .CLK40_i       (clk40),
        .nTS_i         (nts),
        .A_i           (a),
        .RnW_i         (rnw),
        .TT0_i         (tt0),
        .TT1_i         (tt1),
        .RAM_TA_i      (ram_ta),
        .BURST_CYCLE_i (burst_cycle),
        .nRAMSPACE_o   (nramspace),
        .LA_o          (la),
        .LRnW_o        (lrnw),
        .LTT0_o        (ltt0),
        .LTT1_o        (ltt1),
        .nTA_o         (nta),
        .nTBI_o        (ntbi),
        .nTEA_o        (ntea)
    );

    // ---------------- reference model (timestamps of beats / timeout) ----------------
    int          n = 0;
    bit          m_started = 0, m_final = 0, m_tmo = 0, m_acc = 0, m_br = 0, m_tbi = 0;
    int          m_beats = 0, m_last_beat = -100, m_wait_start = 0, m_tea_at = -100, m_idle_from = 0;
    logic [20:1] m_la = '0;
    logic        m_rnw = 1'b1, m_tt0 = 1'b0, m_tt1 = 1'b0;

    always @(posedge clk80) begin
        n++;
        if (!nreset) begin
            m_started = 0; m_final = 0; m_tmo = 0; m_tbi = 0; m_beats = 0;
            m_last_beat = -100; m_tea_at = -100; m_idle_from = n + 1;
            m_la = '0; m_rnw = 1'b1; m_tt0 = 1'b0; m_tt1 = 1'b0;
        end else if (m_started && !m_final && !m_tmo) begin
            if (ram_ta && !clk40 && (n - m_last_beat >= 2)) begin
                m_beats++;
                if (m_beats == 1) begin
                    m_acc = m_br && burst_cycle;
                    m_tbi = m_br && !burst_cycle;
                end
                m_last_beat  = n;
                m_wait_start = n;
                if (m_acc) m_la[3:2] = m_la[3:2] + 2'd1;
                if (!m_acc || m_beats == 4) begin
                    m_final = 1;
                    m_idle_from = n + 5;
                end
            end else if (n - m_wait_start == 255) begin
                m_tmo = 1;
                m_tea_at = n;
                m_idle_from = n + 3;
            end
        end else if (n >= m_idle_from && !nts && clk40 && a[31:21] == 11'h000) begin
            m_started = 1; m_final = 0; m_tmo = 0; m_tbi = 0; m_beats = 0;
            m_last_beat = -100; m_tea_at = -100; m_wait_start = n; m_idle_from = 1 << 30;
            m_la = a[20:1]; m_rnw = rnw; m_tt0 = tt0; m_tt1 = tt1;
            m_br = tt0 && !tt1;
        end
    end

    logic e_nram, e_nta, e_ntbi, e_ntea;
    always @(negedge clk80) begin
        if (chk_en) begin
            e_nram = !(m_started && !m_final && !m_tmo);
            e_nta  = !(n - m_last_beat <= 1);
            e_ntbi = !(m_tbi && (n - m_last_beat <= 1));
            e_ntea = !(m_tmo && (n - m_tea_at <= 1));
            vectors++;
            if ({nramspace, nta, ntbi, ntea, la, lrnw, ltt0, ltt1} !==
                {e_nram, e_nta, e_ntbi, e_ntea, m_la, m_rnw, m_tt0, m_tt1}) begin
                miscompares++;
                $display("FAIL model cyc=%0d got ram=%b ta=%b tbi=%b tea=%b la=%h rw=%b tt=%b%b exp ram=%b ta=%b tbi=%b tea=%b la=%h rw=%b tt=%b%b",
                         n, nramspace, nta, ntbi, ntea, la, lrnw, ltt1, ltt0,
                         e_nram, e_nta, e_ntbi, e_ntea, m_la, m_rnw, m_tt1, m_tt0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; clk40 then holds the phase of the next rising edge.
    task automatic tick();
        @(negedge clk80);
        clk40 = ~clk40;
    endtask

    task automatic to_hi();
        tick();
        if (!clk40) tick();
    endtask

    task automatic start(input logic [31:0] addr, input logic r, input logic t0, input logic t1);
        to_hi();
        a = addr; rnw = r; tt0 = t0; tt1 = t1; nts = 1'b0;
        tick();
        nts = 1'b1;
    endtask

    int   lo, tbi_lo, k;
    logic [7:0] seq;

    initial begin
        nreset = 1'b0; clk40 = 1'b0; nts = 1'b1; a = '0; rnw = 1'b1;
        tt0 = 1'b0; tt1 = 1'b0; ram_ta = 1'b0; burst_cycle = 1'b0;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        chk("rst_nram", nramspace, 1); chk("rst_nta", nta, 1); chk("rst_ntea", ntea, 1);
        chk("rst_la", la, 0); chk("rst_lrnw", lrnw, 1);
        nreset = 1'b1;
        repeat (3) tick();

        // single read
        start(32'h0001_2344, 1'b1, 1'b0, 1'b0);
        chk("single_nram_req", nramspace, 0); chk("single_la", la, 20'h091A2);
        ram_ta = 1'b1;
        tick();
        chk("single_nta_beat", nta, 0); chk("single_nram_drop", nramspace, 1);
        ram_ta = 1'b0;
        tick(); chk("single_nta_hold", nta, 0);
        tick(); chk("single_nta_end", nta, 1);
        repeat (6) tick();

        // accepted burst with line wrap
        burst_cycle = 1'b1;
        start(32'h0001_234C, 1'b1, 1'b1, 1'b0);
        chk("burst_la0", la, 20'h091A6);
        ram_ta = 1'b1; seq = '0; lo = 0; tbi_lo = 0;
        for (int i = 0; i < 4; i++) begin
            seq = {seq[5:0], la[3:2]};
            tick(); lo += int'(!nta); tbi_lo += int'(!ntbi);
            tick(); lo += int'(!nta); tbi_lo += int'(!ntbi);
        end
        ram_ta = 1'b0;
        tick();
        chk("burst_wrap_seq", seq, 8'hC6); chk("burst_nta_cycles", lo, 8);
        chk("burst_ntbi", tbi_lo, 0); chk("burst_nta_end", nta, 1);
        chk("burst_la_end", la, 20'h091A6);
        repeat (6) tick();

        // burst refused by the controller
        burst_cycle = 1'b0;
        start(32'h0000_0040, 1'b1, 1'b1, 1'b0);
        ram_ta = 1'b1;
        tick();
        chk("inhib_nta", nta, 0); chk("inhib_ntbi", ntbi, 0); chk("inhib_nram", nramspace, 1);
        ram_ta = 1'b0;
        tick(); chk("inhib_ntbi_hold", ntbi, 0);
        tick(); chk("inhib_nta_end", nta, 1); chk("inhib_ntbi_end", ntbi, 1);
        repeat (6) tick();

        // outside chip RAM
        start(32'h0020_0000, 1'b1, 1'b0, 1'b0);
        chk("miss_nram", nramspace, 1);
        ram_ta = 1'b1; lo = 0;
        repeat (6) begin tick(); lo += int'(!nta); end
        chk("miss_nta", lo, 0);
        ram_ta = 1'b0;
        repeat (3) tick();

        // timeout
        start(32'h0000_0100, 1'b1, 1'b0, 1'b0);
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            tick(); k = i;
            if (!ntea) break;
        end
        chk("tmo_cycles", k, 255); chk("tmo_nram", nramspace, 1); chk("tmo_nta", nta, 1);
        tick(); chk("tmo_ntea_hold", ntea, 0);
        tick(); chk("tmo_ntea_end", ntea, 1);
        ram_ta = 1'b1; lo = 0;
        repeat (6) begin tick(); lo += int'(!nta); end
        chk("tmo_late_ta", lo, 0);
        ram_ta = 1'b0;
        repeat (3) tick();

        // reset during a burst, then a fresh write
        burst_cycle = 1'b1;
        start(32'h0000_0080, 1'b0, 1'b1, 1'b0);
        ram_ta = 1'b1;
        tick(); tick();
        chk("rstmid_hold", nta, 0);
        nreset = 1'b0;
        tick();
        chk("rstmid_nta", nta, 1); chk("rstmid_nram", nramspace, 1); chk("rstmid_la", la, 0);
        chk("rstmid_lrnw", lrnw, 1); chk("rstmid_ltt0", ltt0, 0);
        nreset = 1'b1; ram_ta = 1'b0;
        tick();
        start(32'h0000_0010, 1'b1, 1'b0, 1'b0);
        ram_ta = 1'b1; lo = 0;
        repeat (4) begin tick(); lo += int'(!nta); ram_ta = 1'b0; end
        chk("rstmid_fresh_nta", lo, 2);
        repeat (4) tick();

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            nts = ($urandom_range(0, 7) != 0);
            a = {(($urandom_range(0, 1) == 1) ? 11'h000 : 11'($urandom)), 21'($urandom)};
            rnw = 1'($urandom_range(0, 1));
            tt0 = 1'($urandom_range(0, 1));
            tt1 = 1'($urandom_range(0, 1));
            ram_ta = ($urandom_range(0, 3) == 0);
            burst_cycle = 1'($urandom_range(0, 1));
            nreset = ($urandom_range(0, 999) != 0);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
